// File: rtl/perf_counter_bank.sv
// rtl/perf_counter_bank.sv - memory-mapped bank of event counters with hi-word snapshot reads
module perf_counter_bank #(
    parameter int          NUM_CH    = 6,
    parameter int          CNT_WIDTH = 16,
    parameter logic [15:0] BASE_ADDR = 16'hFF00
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] event_in,
    input  logic [15:0]       mem_address,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [15:0]       mem_wdata,
    output logic              hit,
    output logic [15:0]       mem_rdata,
    output logic              resp
);
    localparam logic [15:0] WIN_BYTES = 16'(4 * NUM_CH + 4);

    typedef enum logic {IDLE, ACK} state_t;
    state_t state, state_next;

    logic [CNT_WIDTH-1:0] cnt    [NUM_CH];
    logic [15:0]          shadow [NUM_CH];
    logic                 freeze, saturate;
    logic [NUM_CH-1:0]    ovf;

    logic [15:0] offset, rdata;
    logic [3:0]  sel;
    logic        sel_hi, req, do_rd, do_wr, ctrl_wr, ovf_wr, clear_all, hit_ch;
    logic [47:0] ext;

    logic [CNT_WIDTH-1:0] lo_val  [NUM_CH];
    logic [CNT_WIDTH-1:0] hi_val  [NUM_CH];
    logic [15:0]          lo_word [NUM_CH];
    logic [15:0]          hi_word [NUM_CH];
    logic [NUM_CH-1:0]    lo_wr, hi_wr, lo_rd, inc, ovf_set;

    // BASE_ADDR and the window size are even, so address bit 0 cannot change hit.
    assign offset = mem_address - BASE_ADDR;
    assign hit    = offset < WIN_BYTES;
    assign sel    = offset[5:2];
    assign sel_hi = offset[1];
    assign resp   = (state == ACK);

    always_comb begin
        state_next = state;
        req        = 1'b0;
        case (state)
            IDLE: if ((mem_read | mem_write) & hit) begin
                req        = 1'b1;
                state_next = ACK;
            end
            ACK:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign do_wr     = req & mem_write;
    assign do_rd     = req & mem_read & ~mem_write;
    assign ctrl_wr   = do_wr & (sel == 4'(NUM_CH)) & ~sel_hi;
    assign ovf_wr    = do_wr & (sel == 4'(NUM_CH)) & sel_hi;
    assign clear_all = ctrl_wr & mem_wdata[1];

    // Per-channel store values, word views and the clear > store > event priority.
    always_comb begin
        ext     = '0;
        hit_ch  = 1'b0;
        lo_val  = '{default: '0};
        hi_val  = '{default: '0};
        lo_word = '{default: '0};
        hi_word = '{default: '0};
        lo_wr   = '0;
        hi_wr   = '0;
        lo_rd   = '0;
        inc     = '0;
        ovf_set = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ext        = 48'(cnt[i]);
            lo_word[i] = ext[15:0];
            hi_word[i] = ext[31:16];
            ext[15:0]  = mem_wdata;
            lo_val[i]  = ext[CNT_WIDTH-1:0];
            ext        = 48'(cnt[i]);
            ext[31:16] = mem_wdata;
            hi_val[i]  = ext[CNT_WIDTH-1:0];
            hit_ch     = (sel == 4'(i));
            lo_wr[i]   = do_wr & hit_ch & ~sel_hi;
            hi_wr[i]   = do_wr & hit_ch & sel_hi & (CNT_WIDTH > 16);
            lo_rd[i]   = do_rd & hit_ch & ~sel_hi;
            inc[i]     = event_in[i] & ~freeze & ~clear_all & ~lo_wr[i] & ~hi_wr[i];
            ovf_set[i] = inc[i] & (cnt[i] == '1);
        end
    end

    always_comb begin
        rdata = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (sel == 4'(i)) rdata = sel_hi ? shadow[i] : lo_word[i];
        end
        if (sel == 4'(NUM_CH)) rdata = sel_hi ? 16'(ovf) : {13'b0, saturate, 1'b0, freeze};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            mem_rdata <= '0;
            freeze    <= 1'b0;
            saturate  <= 1'b0;
            ovf       <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt[i]    <= '0;
                shadow[i] <= '0;
            end
        end else begin
            state     <= state_next;
            mem_rdata <= do_rd ? rdata : '0;
            if (ctrl_wr) begin
                freeze   <= mem_wdata[0];
                saturate <= mem_wdata[2];
            end
            if (clear_all) ovf <= '0;
            else           ovf <= (ovf & ~(ovf_wr ? mem_wdata[NUM_CH-1:0] : '0)) | ovf_set;
            for (int i = 0; i < NUM_CH; i++) begin
                if (clear_all) begin
                    cnt[i]    <= '0;
                    shadow[i] <= '0;
                end else begin
                    if (lo_wr[i])      cnt[i] <= lo_val[i];
                    else if (hi_wr[i]) cnt[i] <= hi_val[i];
                    else if (inc[i])   cnt[i] <= (saturate && cnt[i] == '1) ? cnt[i]
                                                                            : cnt[i] + CNT_WIDTH'(1);
                    if (lo_rd[i]) shadow[i] <= hi_word[i];
                end
            end
        end
    end
endmodule

// File: doc/perf_counter_bank.md
# perf_counter_bank

Parametrised, memory-mapped bank of event counters for the LC-3b pipeline: NUM_CH independent counters of CNT_WIDTH bits, incremented by single-cycle event pulses (cache hits/misses, branch mispredicts, stalls). Occupies an address window in the data-memory stage. Loads/stores to the window are answered locally instead of going to the memory bus. Adds what the fixed counter mux lacks: configurable width and channel count, preload/clear by store, freeze, wrap/saturate mode, sticky overflow flags, and coherent 32-bit reads through a hi-word snapshot.

## Interface
- NUM_CH, 6: number of counter channels, 1..8
- CNT_WIDTH, 16: counter width in bits, 8..32
- BASE_ADDR, 16'hFF00: byte address of window start; 32-byte aligned
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- event_in  in  NUM_CH  per-channel increment pulse; bit i increments counter i by 1
- mem_address  in  16  byte address of the MEM-stage access; bit 0 ignored
- mem_read  in  1  load request
- mem_write  in  1  store request
- mem_wdata  in  16  store data
- hit  out  1  combinational; high when mem_address[15:1] falls inside the window
- mem_rdata  out  16  registered read data; valid while resp is high
- resp  out  1  registered single-cycle access acknowledge

## Operation
- Address map, word offsets from BASE_ADDR:
  - channel i lo word at 4i
  - channel i hi word at 4i+2
  - CTRL at 4·NUM_CH
  - OVF at 4·NUM_CH+2
  - all other in-window offsets read 0 and ignore writes.
- Window size is 4·NUM_CH+4 bytes. hit = (mem_address − BASE_ADDR) < window size.
- Lo read: returns counter[15:0], zero-extended when CNT_WIDTH<16. Copies counter[CNT_WIDTH-1:16] into that channel's hi shadow; the shadow is 0 when CNT_WIDTH≤16.
- Hi read: returns the shadow, not the live counter. Software reads lo then hi for a coherent value.
- Lo write: counter[15:0] ← mem_wdata, truncated to CNT_WIDTH; upper bits unchanged.
- Hi write: counter[CNT_WIDTH-1:16] ← mem_wdata; ignored when CNT_WIDTH≤16.
- CTRL bits:
  - bit0 freeze: all event_in ignored while set.
  - bit1 clear_all: write-only, self-clearing; zeroes all counters, shadows and OVF.
  - bit2 saturate: 1 = counters hold at max; 0 = counters wrap to 0.
  - Other bits read 0.
- OVF: bit i is sticky and set when counter i increments at all-ones, in either mode. Write-1-to-clear. Bits ≥ NUM_CH read 0.
- Access FSM:
  - IDLE: on (mem_read|mem_write)&hit, sample the address/data, perform the access, go to ACK.
  - ACK: resp=1 and mem_rdata valid (0 for writes); unconditional return to IDLE.
- A request still held in IDLE after ACK is a new access. The requester drops or changes it on resp.
- Priority per channel in one cycle: clear_all > store to that channel > event increment. A losing event is dropped and its OVF is not set.
- A read sampled in the same cycle as an event returns the pre-increment value.
- Events keep counting during bus accesses, other than the collisions above.

## Timing
- Reset, synchronous: counters=0, shadows=0, CTRL=0 (counting, wrap mode), OVF=0, FSM=IDLE, resp=0, mem_rdata=0.
- Increment latency: event_in high at edge N gives the updated value at edge N+1.
- Access latency: request sampled at edge N gives resp high for exactly the cycle after edge N, then low at edge N+1 regardless of inputs.
- A store takes effect at edge N.
- Reset asserted while in ACK: resp is forced to 0 at the next edge and the pending access is discarded.
- hit is purely combinational and does not depend on FSM state.

## Test plan
- Reset, then pulse event_in[2] for 5 cycles, then load lo ch2 → resp one cycle later, mem_rdata=5; hit=1 at BASE_ADDR+8.
- CNT_WIDTH=32: write hi ch0=16'h0001, write lo ch0=16'hFFFF, one event, read lo → 16'h0000. One more event before reading hi; hi returns the shadow 16'h0002, not the live value.
- CNT_WIDTH=8, wrap mode, counter=8'hFF plus event → 0, OVF[0]=1. Write OVF=1 → OVF reads 0. With saturate=1 at 8'hFF plus event → stays 8'hFF, OVF set.
- Store lo ch1=7 in the same cycle as event_in[1] → ch1 reads 7. clear_all in the same cycle as events on all channels → all counters 0.
- CTRL=1 (freeze): 10 events → counts unchanged. Write CTRL=0, 1 event → count +1. CTRL reads back 0 after a clear_all write.
- Access at BASE_ADDR−2 and at BASE_ADDR+4·NUM_CH+4 → hit=0 and no resp. Assert rst during ACK → resp=0 next cycle and all registers reset.
